// File: rtl/avr_link_pkg.sv
// avr_link_pkg: shared definitions for the FPGA->AVR serial link
//   tx_state_e       serializer FSM states
//   CLK_PER_BIT_500K clk cycles per bit at 50 MHz / 500 kbaud
//   MAX_REQ          largest supported requester count
//   rr_next          round-robin successor of an index, wrapping at n
package avr_link_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
    localparam int CLK_PER_BIT_500K = 100;
    localparam int MAX_REQ = 8;
    function automatic logic [2:0] rr_next(input logic [2:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? 3'd0 : idx + 3'd1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or after ptr
//   req_i  requester valid bits
//   ptr_i  index searched first
//   gnt_o  one-hot grant, all zero when nothing is valid
//   id_o   index of the granted requester
module rr_arbiter
    import avr_link_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [2:0]         id_o
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [2:0]           off;
    logic [3:0]           sum;
    // Rotating the doubled vector by ptr turns the wrapped search into a plain lowest-set-bit search.
    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (dbl[k]) off = 3'(k);
        sum = {1'b0, ptr_i} + {1'b0, off};
        id_o = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
        for (int k = 0; k < NUM_REQ; k++)
            gnt_o[k] = (|req_i) && (id_o == 3'(k));
    end
endmodule

// File: rtl/avr_serial_tx_arbiter.sv
// avr_serial_tx_arbiter: round-robin sharing of the 8N1 FPGA->AVR serial link among NUM_REQ byte sources
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_valid    requester i has a byte pending
//   req_data     byte of requester i in bits [8i+7:8i]
//   req_ready    one-cycle pulse when the byte of requester i is captured
//   avr_rx_busy  AVR receive buffer full (asynchronous)
//   avr_rx       serial line to the AVR, idle high
//   grant_id     requester currently (or last) sent
//   tx_busy      high from capture until the end of the stop bit
module avr_serial_tx_arbiter
    import avr_link_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CLK_PER_BIT = CLK_PER_BIT_500K
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 avr_rx_busy,
    output logic                 avr_rx,
    output logic [2:0]           grant_id,
    output logic                 tx_busy
);
    localparam int BW = $clog2(CLK_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

    tx_state_e            state_q, state_d;
    logic [1:0]           sync_q;
    logic [BW-1:0]        baud_q;
    logic [2:0]           bit_q;
    logic [7:0]           shift_q;
    logic [2:0]           ptr_q;
    logic [2:0]           grant_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 tx_busy_q;
    logic [NUM_REQ-1:0]   gnt;
    logic [2:0]           win_id;
    logic [7:0]           sel_byte;
    logic                 busy_s, bit_end, start_frame;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .id_o  (win_id)
    );

    assign busy_s      = sync_q[1];
    assign bit_end     = baud_q == BAUD_LAST;
    assign start_frame = state_q == IDLE && !busy_s && |req_valid;
    assign req_ready   = ready_q;
    assign grant_id    = grant_q;
    assign tx_busy     = tx_busy_q;

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (gnt[k]) sel_byte = req_data[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_frame ? START : IDLE;
            START:   state_d = bit_end ? DATA : START;
            DATA:    state_d = (bit_end && bit_q == 3'd7) ? STOP : DATA;
            default: state_d = bit_end ? IDLE : STOP;
        endcase
    end

    // Driven straight from state so an asserted reset forces the line idle without waiting for a clock.
    always_comb avr_rx = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;

    // Both sync stages reset to busy so no frame starts until the AVR has been seen ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            tx_busy_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], avr_rx_busy};
            ready_q <= '0;
            if (start_frame) begin
                shift_q   <= sel_byte;
                grant_q   <= win_id;
                ready_q   <= gnt;
                ptr_q     <= rr_next(win_id, NUM_REQ);
                tx_busy_q <= 1'b1;
                baud_q    <= '0;
                bit_q     <= '0;
            end else if (state_q != IDLE) begin
                baud_q <= bit_end ? '0 : baud_q + 1'b1;
                if (bit_end && state_q == DATA) begin
                    shift_q <= shift_q >> 1;
                    bit_q   <= bit_q + 3'd1;
                end
                if (bit_end && state_q == STOP) tx_busy_q <= 1'b0;
            end
        end
    end
endmodule
